instruction_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory read port. Owns the fetch PC and

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/instruction_fetch_unit.sv | 74 +++++++
 tb/tb_instruction_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: the NOP used on idle outputs, the default
// reset PC, and the {pc, instr} entry carried through the prefetch FIFO.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO of fetch entries. Flush overrides push and pop.
// Latency: a pushed entry reaches the head one cycle later; a push at full is taken only alongside a pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner feeding a show-ahead prefetch FIFO into decode; redirects flush and retarget.
// Latency: 1 cycle address-to-OutValid, 2 cycles redirect-to-target; fetch stalls while FIFO is full and not popped.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPC,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutPC,
  output logic [31:0] OutInstruction,
  output logic        MisalignFault
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          fault_q, fault_d;
  logic          push, pop, empty;
  logic [CW-1:0] count;
  fetch_entry_t  head, din;

  assign din = '{pc: fetch_pc_q, instr: ImemInstruction};
  assign pop = !empty && OutReady;

  always_comb begin
    push       = 1'b0;
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q;
    if (RedirectValid) begin
      fetch_pc_d = RedirectPC;
      fault_d    = |RedirectPC[1:0];
    end else if (!fault_q && ((count < CW'(FIFO_DEPTH)) || pop)) begin
      push       = 1'b1;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (RedirectValid),
    .din   (din),
    .dout  (head),
    .empty (empty),
    .count (count)
  );

  assign ImemAddress    = fetch_pc_q;
  assign MisalignFault  = fault_q;
  assign OutValid       = !empty;
  assign OutPC          = empty ? 32'h0 : head.pc;
  assign OutInstruction = empty ? NOP_INSTR : head.instr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized redirects and
// back-pressure, compared each cycle against a queue-based reference model.
module tb_instruction_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ImemAddress, ImemInstruction, RedirectPC, OutPC, OutInstruction;
  logic        RedirectValid = 1'b0, OutReady = 1'b0, OutValid, MisalignFault;
  logic [31:0] rom_key = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_entry_t mq[$];
  logic [31:0]  mpc;
  logic         mfault;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a >> 2) ^ rom_key;
  endfunction

  assign ImemInstruction = rom(ImemAddress);

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .ImemAddress(ImemAddress), .ImemInstruction(ImemInstruction),
    .RedirectValid(RedirectValid), .RedirectPC(RedirectPC), .OutValid(OutValid),
    .OutReady(OutReady), .OutPC(OutPC), .OutInstruction(OutInstruction),
    .MisalignFault(MisalignFault)
  );

  task automatic model_reset();
    mq.delete();
    mpc    = 32'h0;
    mfault = 1'b0;
  endtask

  // Decode sees the head, takes it if ready; fetch fills any free slot unless faulted.
  task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
    fetch_entry_t e;
    if (rv) begin
      mq.delete();
      mpc    = rpc;
      mfault = (rpc % 4) != 0;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (!mfault && mq.size() < DEPTH) begin
        e.pc = mpc;
        e.instr = rom(mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  function automatic logic [97:0] exp_vec();
    if (mq.size() == 0) return {mpc, 1'b0, 32'h0, NOP, mfault};
    return {mpc, 1'b1, mq[0].pc, mq[0].instr, mfault};
  endfunction

  function automatic logic [97:0] dut_vec();
    return {ImemAddress, OutValid, OutPC, OutInstruction, MisalignFault};
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
    RedirectValid = rv;
    RedirectPC    = rpc;
    OutReady      = rdy;
    model_step(rv, rpc, rdy);
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({ImemAddress, OutValid, OutPC, OutInstruction, MisalignFault} !== {32'h0, 1'b0, 32'h0, NOP, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state got addr=%h v=%b pc=%h ins=%h f=%b", ImemAddress, OutValid, OutPC, OutInstruction, MisalignFault);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_cmp++;
      if ({OutValid, OutPC, OutInstruction} !== {1'b1, 32'(4 * i), 32'(i)}) begin
        n_bad++;
        $display("FAIL stream[%0d] got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, OutValid, OutPC, OutInstruction, 32'(4 * i), 32'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] next_pc;
    test_reset();
    for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 1'b0);
    n_cmp++;
    if ({ImemAddress, OutValid, OutPC} !== {32'h8, 1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL stall_hold got addr=%h v=%b pc=%h want addr=8 v=1 pc=0", ImemAddress, OutValid, OutPC);
    end
    next_pc = 32'h0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (OutPC !== next_pc || OutValid !== 1'b1) begin
        n_bad++;
        $display("FAIL resume[%0d] got v=%b pc=%h want v=1 pc=%h", i, OutValid, OutPC, next_pc);
      end
      next_pc = next_pc + 32'd4;
      drive(1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_redirect();
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h40, 1'b1);
    n_cmp++;
    if ({OutValid, ImemAddress} !== {1'b0, 32'h40}) begin
      n_bad++;
      $display("FAIL redirect_n1 got v=%b addr=%h want v=0 addr=40", OutValid, ImemAddress);
    end
    drive(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if ({OutValid, OutPC, OutInstruction} !== {1'b1, 32'h40, 32'h10}) begin
      n_bad++;
      $display("FAIL redirect_n2 got v=%b pc=%h ins=%h want v=1 pc=40 ins=10", OutValid, OutPC, OutInstruction);
    end
  endtask

  task automatic test_misalign();
    drive(1'b1, 32'h42, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({MisalignFault, OutValid, ImemAddress} !== {1'b1, 1'b0, 32'h42}) begin
        n_bad++;
        $display("FAIL misalign[%0d] got f=%b v=%b addr=%h want f=1 v=0 addr=42", i, MisalignFault, OutValid, ImemAddress);
      end
      drive(1'b0, 32'h0, 1'b1);
    end
    drive(1'b1, 32'h80, 1'b1);
    n_cmp++;
    if ({MisalignFault, OutValid} !== 2'b00) begin
      n_bad++;
      $display("FAIL fault_clear got f=%b v=%b want f=0 v=0", MisalignFault, OutValid);
    end
    drive(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if ({OutValid, OutPC} !== {1'b1, 32'h80}) begin
      n_bad++;
      $display("FAIL realign got v=%b pc=%h want v=1 pc=80", OutValid, OutPC);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ImemAddress, OutValid, OutPC, OutInstruction, MisalignFault} !== {32'h0, 1'b0, 32'h0, NOP, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset got addr=%h v=%b pc=%h ins=%h f=%b", ImemAddress, OutValid, OutPC, OutInstruction, MisalignFault);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if ({OutValid, OutPC, ImemAddress} !== {1'b1, 32'h0, 32'h4}) begin
      n_bad++;
      $display("FAIL restart got v=%b pc=%h addr=%h want v=1 pc=0 addr=4", OutValid, OutPC, ImemAddress);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'hFFFF_FFFC, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if ({ImemAddress, OutValid, OutPC} !== {32'h0, 1'b1, 32'hFFFF_FFFC}) begin
      n_bad++;
      $display("FAIL wrap got addr=%h v=%b pc=%h want addr=0 v=1 pc=fffffffc", ImemAddress, OutValid, OutPC);
    end
    drive(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if ({OutValid, OutPC} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL wrap_next got v=%b pc=%h want v=1 pc=0", OutValid, OutPC);
    end
  endtask

  task automatic test_random();
    logic        rv;
    logic [31:0] rpc;
    rom_key = $urandom;
    test_reset();
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 9) == 0);
      rpc = {$urandom_range(0, 32'h3FFF), 2'b00};
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      drive(rv, rpc, 1'($urandom_range(0, 2) != 0));
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random[%0d] got %h want %h (addr,v,pc,ins,fault)", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    RedirectPC = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
